// File: rtl/kbd_event_ctrl.sv
// PS/2 scan-code decoder with modifier tracking and an event FIFO.
// Prefix bytes E0/F0 qualify the next byte, which completes one event.
module kbd_event_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       evt_ready,
    input  logic       ovf_clr,
    output logic       evt_valid,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic       evt_shift,
    output logic       evt_ctrl,
    output logic [4:0] fifo_cnt,
    output logic       overflow,
    output logic [7:0] make_cnt
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       shift;
        logic       ctrl;
    } evt_t;

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   tmo;
    logic            done;
    logic            d_ext;
    logic            d_brk;

    logic            shift_l, shift_r, ctrl_l, ctrl_r;
    logic            sl_n, sr_n, cl_n, cr_n;
    evt_t            new_evt;

    evt_t            mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [4:0]      cnt;
    logic            full;
    logic            pop;
    logic            push_ok;
    logic            drop;
    evt_t            head;

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        d_ext     = (state == EXT) || (state == EXT_BRK);
        d_brk     = (state == BRK) || (state == EXT_BRK);
        if (rx_valid) begin
            unique case (state)
                IDLE: begin
                    if (rx_data == 8'hE0)      state_nxt = EXT;
                    else if (rx_data == 8'hF0) state_nxt = BRK;
                    else                       done = 1'b1;
                end
                EXT: begin
                    if (rx_data == 8'hF0)      state_nxt = EXT_BRK;
                    else if (rx_data == 8'hE0) state_nxt = EXT;
                    else                       done = 1'b1;
                end
                BRK: begin
                    if (rx_data == 8'hF0) state_nxt = BRK;
                    else                  done = 1'b1;
                end
                EXT_BRK: begin
                    if (rx_data == 8'hE0 || rx_data == 8'hF0)
                        state_nxt = EXT_BRK;
                    else
                        done = 1'b1;
                end
            endcase
            if (done) state_nxt = IDLE;
        end
    end

    // Any byte restarts the timeout; a stalled prefix falls back to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            tmo   <= '0;
        end else if (rx_valid) begin
            state <= state_nxt;
            tmo   <= '0;
        end else if (state != IDLE) begin
            if (tmo == TW'(TIMEOUT - 1)) begin
                state <= IDLE;
                tmo   <= '0;
            end else begin
                tmo <= tmo + TW'(1);
            end
        end else begin
            tmo <= '0;
        end
    end

    always_comb begin
        sl_n = shift_l;
        sr_n = shift_r;
        cl_n = ctrl_l;
        cr_n = ctrl_r;
        if (done) begin
            if (!d_ext && rx_data == 8'h12) sl_n = !d_brk;
            if (!d_ext && rx_data == 8'h59) sr_n = !d_brk;
            if (rx_data == 8'h14) begin
                if (d_ext) cr_n = !d_brk;
                else       cl_n = !d_brk;
            end
        end
        new_evt = {rx_data, d_ext, d_brk, sl_n | sr_n, cl_n | cr_n};
    end

    assign full    = (cnt == 5'(FIFO_DEPTH));
    assign pop     = (cnt != 5'd0) && evt_ready;
    assign push_ok = done && (!full || pop);
    assign drop    = done && full && !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_l  <= 1'b0;
            shift_r  <= 1'b0;
            ctrl_l   <= 1'b0;
            ctrl_r   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
            make_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            shift_l <= sl_n;
            shift_r <= sr_n;
            ctrl_l  <= cl_n;
            ctrl_r  <= cr_n;
            if (push_ok) begin
                mem[wr_ptr] <= new_evt;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (push_ok && !pop)      cnt <= cnt + 5'd1;
            else if (!push_ok && pop) cnt <= cnt - 5'd1;
            // A fresh drop wins over a clear in the same cycle.
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
            if (done && !d_brk) make_cnt <= make_cnt + 8'd1;
        end
    end

    assign head      = mem[rd_ptr];
    assign evt_valid = (cnt != 5'd0);
    assign evt_code  = head.code;
    assign evt_ext   = head.ext;
    assign evt_break = head.brk;
    assign evt_shift = head.shift;
    assign evt_ctrl  = head.ctrl;
    assign fifo_cnt  = cnt;

endmodule

// File: doc/kbd_event_ctrl.md
KBD_EVENT_CTRL -- requirements
Module: kbd_event_ctrl

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of event FIFO entries (power of 2, 2..16).
REQ-002 The block SHALL have parameter TIMEOUT, default 50000, meaning the clk cycles a prefix state may wait for its next byte.
REQ-003 The block SHALL have port clk, input, 1, system clock.
REQ-004 The block SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-005 The block SHALL have port rx_data, input, 8, scan-code byte from the PS/2 receiver.
REQ-006 The block SHALL have port rx_valid, input, 1, one-cycle strobe qualifying rx_data.
REQ-007 The block SHALL have port evt_ready, input, 1, consumer accepts the head event.
REQ-008 The block SHALL have port ovf_clr, input, 1, clears the overflow flag.
REQ-009 The block SHALL have port evt_valid, output, 1, FIFO non-empty.
REQ-010 The block SHALL have port evt_code, output, 8, head event scan code.
REQ-011 The block SHALL have port evt_ext, output, 1, head event had an E0 prefix.
REQ-012 The block SHALL have port evt_break, output, 1, head event is a release.
REQ-013 The block SHALL have port evt_shift, output, 1, shift state stored with the head event.
REQ-014 The block SHALL have port evt_ctrl, output, 1, ctrl state stored with the head event.
REQ-015 The block SHALL have port fifo_cnt, output, 5, current FIFO occupancy.
REQ-016 The block SHALL have port overflow, output, 1, sticky flag set when an event is dropped.
REQ-017 The block SHALL have port make_cnt, output, 8, count of decoded make events.

Function
REQ-018 The decoder FSM SHALL have the states IDLE, EXT, BRK and EXT_BRK, and SHALL act only in cycles where rx_valid=1.
REQ-019 The FSM transitions SHALL be: IDLE+E0 -> EXT; IDLE+F0 -> BRK; EXT+F0 -> EXT_BRK; EXT+E0 -> EXT; BRK+F0 -> BRK; EXT_BRK+E0 or F0 -> EXT_BRK; any other byte in any state -> IDLE, completing an event.
REQ-020 A completed event SHALL carry code=rx_data, ext=1 if it came from EXT or EXT_BRK, and break=1 if it came from BRK or EXT_BRK.
REQ-021 The modifier registers SHALL behave as follows: shift_l is set by a make of 12 and cleared by a break of 12 (ext=0); shift_r likewise for 59; ctrl_l for 14 with ext=0; ctrl_r for 14 with ext=1.
REQ-022 An event SHALL store shift=shift_l|shift_r and ctrl=ctrl_l|ctrl_r, taken after that event's own modifier update is applied.
REQ-023 A make of a key already held (auto-repeat) SHALL produce a normal event.
REQ-024 A timeout counter SHALL reset on every rx_valid, run while the FSM is not in IDLE, and force the FSM to IDLE with no event when it reaches TIMEOUT-1.
REQ-025 The FIFO push SHALL occur on the clk edge that samples the completing byte, so evt_valid rises exactly 1 cycle after that rx_valid when the FIFO was empty.
REQ-026 The FIFO outputs SHALL be driven directly from the head entry; evt_valid SHALL equal (fifo_cnt!=0).
REQ-027 A pop SHALL occur when evt_valid and evt_ready are both 1; evt_ready while the FIFO is empty SHALL have no effect.
REQ-028 A simultaneous push and pop SHALL leave fifo_cnt unchanged, including when the FIFO is full; in that case the push SHALL succeed.
REQ-029 A push when full with no pop SHALL drop the new event, leave the FIFO unchanged and set overflow; modifier registers SHALL still update.
REQ-030 overflow SHALL be cleared by ovf_clr; if ovf_clr and a new drop coincide, overflow SHALL remain 1.
REQ-031 make_cnt SHALL increment on every completed make event, including dropped ones, and SHALL wrap from 255 to 0.
REQ-032 The read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-033 When rst=0, the block SHALL immediately force: FSM=IDLE, timeout counter=0, all modifier registers=0, FIFO pointers and fifo_cnt=0, evt_valid=0, evt_code=0, evt_ext=0, evt_break=0, evt_shift=0, evt_ctrl=0, overflow=0, make_cnt=0.
REQ-034 Assertion of reset mid-sequence (for example after an E0) SHALL discard the partial sequence and all buffered events.

Verification
REQ-035 Bytes 1C,F0,1C with evt_ready=0 -> fifo_cnt=2; head is {1C, ext=0, brk=0}, then {1C, brk=1}; make_cnt=1.
REQ-036 Bytes 12,1C,F0,1C,F0,12 with evt_ready=1 -> the events in order carry shift values 1,1,1,0; the 1C make carries shift=1.
REQ-037 Bytes E0,14,E0,F0,14 -> events {14, ext=1, brk=0, ctrl=1} then {14, ext=1, brk=1, ctrl=0}.
REQ-038 Send 5 makes with evt_ready=0 (FIFO_DEPTH=4) -> fifo_cnt=4, overflow=1, make_cnt=5; then push and pop in the same cycle while full -> fifo_cnt stays 4; assert ovf_clr -> overflow=0.
REQ-039 Send E0, then idle for TIMEOUT cycles, then send 1C -> one event {1C, ext=0}.
REQ-040 Send E0,F0, then assert rst low for 1 cycle, then send 1C -> one event {1C, ext=0, brk=0}, with fifo_cnt=0 before the 1C arrives.
